ahb_pwm_multi: RTL

- Parametrised multi-channel PWM peripheral on an AHB-Lite slave port.
- Successor to the single-channel HLS PWM wrapper. It has a native shared period counter and NUM_CH independent duty channels.
- Duty and period use shadow registers that reload glitch-free at period wrap. A wrap interrupt is provided.
- Sits on the AHB-Lite fabric as a slave, alongside the other accelerator wrappers.

---
 rtl/ahb_pwm_multi.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_pwm_multi.sv
// ahb_pwm_multi: multi-channel PWM peripheral on an AHB-Lite slave port.
// One shared period counter drives NUM_CH duty comparators. PERIOD and DUTY
// are written into shadow registers and copied into the active registers
// at period wrap (or continuously while RUN=0), so a running waveform never
// glitches. A sticky WRAP flag provides a level interrupt.
//
// Build option: define AHB_PWM_POLARITY_EN to add the POLARITY register at
// 0x00C, which inverts individual channel outputs.
//
// Bus handshake: an address phase is accepted when hsel & hready & htrans[1];
// the following cycle is its data phase, which always completes in one cycle
// (hready_resp=1, hresp=OKAY). A write commits hwdata at the end of the data
// phase while hready=1; a read returns data from the registered address.
//
// Reset: HRESETn is synchronous and active-high (HRESETn=1 resets).

module ahb_pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic [31:0]       hrdata,
    output logic              hready_resp,
    output logic [1:0]        hresp,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam int CTRL_W = 2 + NUM_CH;
    localparam int WORD_W = ADDR_W - 2;

    // Registered address phase
    logic              valid_q;
    logic              write_q;
    logic [WORD_W-1:0] word_q;

    // Programmer-visible registers
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  duty_sh [NUM_CH];
    logic              wrap_q;
    logic [NUM_CH-1:0] pol_q;

    // Counter and active copies
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  duty_act [NUM_CH];

    logic              run;
    logic [NUM_CH-1:0] ch_en;
    logic              irq_en;
    logic              wrap_evt;
    logic              wr_en;
    logic              sel_ctrl;
    logic              sel_period;
    logic              sel_status;
    logic              sel_pol;
    logic [NUM_CH-1:0] sel_duty;
    logic [NUM_CH-1:0] pwm_level;
    logic [31:0]       rdata;

    // hsize, byte-lane and upper address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{hsize, haddr[1:0], haddr[31:ADDR_W], hwdata[31:CNT_W]};

    assign run      = ctrl_q[0];
    assign irq_en   = ctrl_q[1];
    assign ch_en    = ctrl_q[CTRL_W-1:2];
    assign wrap_evt = run && (cnt == period_act);
    assign wr_en    = valid_q && write_q && hready;

    // Word-offset decode of the registered address
    always_comb begin
        sel_ctrl   = (word_q == WORD_W'(0));
        sel_period = (word_q == WORD_W'(1));
        sel_status = (word_q == WORD_W'(2));
`ifdef AHB_PWM_POLARITY_EN
        sel_pol    = (word_q == WORD_W'(3));
`else
        sel_pol    = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            sel_duty[i] = (word_q == WORD_W'(4 + i));
        end
    end

    // Capture the address phase whenever the bus advances
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            word_q  <= '0;
        end else if (hready) begin
            valid_q <= hsel && htrans[1];
            write_q <= hwrite;
            word_q  <= haddr[ADDR_W-1:2];
        end
    end

    // Control and shadow register writes
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            ctrl_q    <= '0;
            period_sh <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
        end else if (wr_en) begin
            if (sel_ctrl)   ctrl_q    <= hwdata[CTRL_W-1:0];
            if (sel_period) period_sh <= hwdata[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_duty[i]) duty_sh[i] <= hwdata[CNT_W-1:0];
            end
        end
    end

`ifdef AHB_PWM_POLARITY_EN
    // Per-channel output inversion
    always_ff @(posedge HCLK) begin
        if (HRESETn)                pol_q <= '0;
        else if (wr_en && sel_pol)  pol_q <= hwdata[NUM_CH-1:0];
    end
`else
    assign pol_q = '0;
`endif

    // Sticky WRAP flag: a wrap in the same cycle as a clear keeps it set
    always_ff @(posedge HCLK) begin
        if (HRESETn)                                  wrap_q <= 1'b0;
        else if (wrap_evt)                            wrap_q <= 1'b1;
        else if (wr_en && sel_status && hwdata[0])    wrap_q <= 1'b0;
    end

    // Shared period counter; actives track shadows when idle, reload at wrap
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            cnt        <= '0;
            period_act <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else if (!run || wrap_evt) begin
            cnt        <= '0;
            period_act <= period_sh;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-channel compare against the active duty
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_level[i] = run && ch_en[i] && (cnt < duty_act[i]);
        end
    end

    // Registered outputs, one cycle behind the counter
    always_ff @(posedge HCLK) begin
        if (HRESETn) pwm_out <= '0;
        else         pwm_out <= pwm_level ^ pol_q;
    end

    // Read mux; unimplemented bits and unmapped offsets return 0
    always_comb begin
        rdata = '0;
        if (sel_ctrl)   rdata[CTRL_W-1:0] = ctrl_q;
        if (sel_period) rdata[CNT_W-1:0]  = period_sh;
        if (sel_status) rdata[0]          = wrap_q;
        if (sel_pol)    rdata[NUM_CH-1:0] = pol_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_duty[i]) rdata[CNT_W-1:0] = duty_sh[i];
        end
    end

    assign hrdata      = (!HRESETn && valid_q && !write_q) ? rdata : 32'h0;
    assign hready_resp = 1'b1;
    assign hresp       = 2'b00;
    assign irq         = wrap_q && irq_en;

endmodule
